// File: rtl/neuron_core_pkg.sv
// Shared definitions for the neuron core: activation type names and the
// saturating adder used by the accumulator and the bias stage.
package neuron_core_pkg;

    localparam string ACT_RELU    = "relu";
    localparam string ACT_SIGMOID = "sigmoid";

    // Widest accumulator the saturating adder supports.
    localparam int SAT_W = 64;

    // Two's-complement add over the low w bits that clamps instead of wrapping:
    // two non-negative operands that produce a negative result go to the
    // largest positive value, and two negative operands that produce a
    // non-negative result go to the most negative value.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               w
    );
        logic [SAT_W-1:0] s;
        logic [SAT_W-1:0] top;
        s   = a + b;
        top = SAT_W'(1) << (w - 1);
        if (!a[w-1] && !b[w-1] && s[w-1]) begin
            sat_add = top - SAT_W'(1);
        end else if (a[w-1] && b[w-1] && !s[w-1]) begin
            sat_add = top;
        end else begin
            sat_add = s;
        end
    endfunction

endpackage

// File: rtl/neuron_weight_ram.sv
// Weight store for one neuron: a single write port and a registered read port.
// A read and a write to the same address in one cycle return the old word.
module neuron_weight_ram #(
    parameter int depth     = 784,
    parameter int addrW     = 10,
    parameter int dataWidth = 16
) (
    input  logic                 clk,
    input  logic                 wen,
    input  logic [addrW-1:0]     waddr,
    input  logic [dataWidth-1:0] wdata,
    input  logic                 ren,
    input  logic [addrW-1:0]     raddr,
    output logic [dataWidth-1:0] rdata
);

    logic [dataWidth-1:0] mem [depth];

    // Write-port update and read-first registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (wen && (int'(waddr) < depth)) begin
            mem[waddr] <= wdata;
        end
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/neuron_core.sv
// One fully-connected neuron: run-time loaded weights and bias, a saturating
// multiply-accumulate over numWeight inputs, and a registered activation.
module neuron_core
    import neuron_core_pkg::*;
#(
    parameter int    layerNo        = 0,
    parameter int    neuronNo       = 0,
    parameter int    numWeight      = 784,
    parameter int    dataWidth      = 16,
    parameter int    sigmoidSize    = 5,
    parameter int    weightIntWidth = 1,
    parameter string actType        = ACT_RELU,
    parameter string sigFile        = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] myinput,
    input  logic                 myinputValid,
    input  logic                 weightValid,
    input  logic                 biasValid,
    input  logic [31:0]          weightValue,
    input  logic [31:0]          biasValue,
    input  logic [31:0]          config_layer_num,
    input  logic [31:0]          config_neuron_num,
    output logic [dataWidth-1:0] out,
    output logic                 outvalid
);

    localparam int addrW = $clog2(numWeight);
    localparam int accW  = 2 * dataWidth;
    localparam logic [addrW:0] lastAddr = (addrW + 1)'(numWeight - 1);
    localparam logic [addrW:0] fullAddr = (addrW + 1)'(numWeight);

    logic                        sel;
    logic                        wen;
    logic [addrW-1:0]            w_addr;
    logic [dataWidth-1:0]        w_in;
    logic [dataWidth-1:0]        w_out;
    logic [addrW:0]              r_addr;
    logic signed [dataWidth-1:0] myinput_d;
    logic signed [accW-1:0]      mul;
    logic [accW-1:0]             sum;
    logic [accW-1:0]             bias;
    logic                        in_valid_d;
    logic                        in_last_d;
    logic                        mul_valid;
    logic                        mul_last;
    logic                        acc_last;
    logic                        bias_go;
    logic                        sig_valid;
    logic                        unused_upper;

    assign sel = (config_layer_num == 32'(layerNo)) && (config_neuron_num == 32'(neuronNo));
    assign unused_upper = ^{weightValue[31:dataWidth], biasValue[31:dataWidth]};

    // Weight write pointer pre-increments from all ones so the first load lands at address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_addr <= '1;
            wen    <= 1'b0;
        end else begin
            wen <= weightValid && sel;
            if (weightValid && sel) begin
                w_addr <= w_addr + 1'b1;
            end
        end
    end

    // Capture the weight word for the following cycle's RAM write.
    always_ff @(posedge clk) begin
        if (weightValid && sel) begin
            w_in <= weightValue[dataWidth-1:0];
        end
    end

    // Bias is kept across resets and stored pre-shifted into the accumulator's fixed-point position.
    always_ff @(posedge clk) begin
        if (biasValid && sel) begin
            bias <= {biasValue[dataWidth-1:0], {dataWidth{1'b0}}};
        end
    end

    neuron_weight_ram #(
        .depth     (numWeight),
        .addrW     (addrW),
        .dataWidth (dataWidth)
    ) u_weight_ram (
        .clk   (clk),
        .wen   (wen),
        .waddr (w_addr),
        .wdata (w_in),
        .ren   (myinputValid),
        .raddr (r_addr[addrW-1:0]),
        .rdata (w_out)
    );

    // Read pointer counts accepted inputs and rewinds once the result has been presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (outvalid) begin
            r_addr <= '0;
        end else if (myinputValid) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Valid flags travel with each sample; the last-sample tag marks the end of the product stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_valid_d <= 1'b0;
            in_last_d  <= 1'b0;
            mul_valid  <= 1'b0;
            mul_last   <= 1'b0;
            acc_last   <= 1'b0;
            bias_go    <= 1'b0;
            sig_valid  <= 1'b0;
            outvalid   <= 1'b0;
        end else begin
            in_valid_d <= myinputValid;
            in_last_d  <= myinputValid && (r_addr == lastAddr);
            mul_valid  <= in_valid_d;
            mul_last   <= in_last_d;
            acc_last   <= mul_last;
            bias_go    <= acc_last;
            sig_valid  <= bias_go && (r_addr == fullAddr);
            outvalid   <= sig_valid;
        end
    end

    // Align the sample with its registered weight, then register the signed product.
    always_ff @(posedge clk) begin
        myinput_d <= myinput;
        mul       <= myinput_d * $signed(w_out);
    end

    // Saturating accumulation of products, followed by the bias once every product is in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (outvalid) begin
            sum <= '0;
        end else if (bias_go && (r_addr == fullAddr)) begin
            sum <= accW'(sat_add(SAT_W'(sum), SAT_W'(bias), accW));
        end else if (mul_valid) begin
            sum <= accW'(sat_add(SAT_W'(sum), SAT_W'(unsigned'(mul)), accW));
        end
    end

    if (actType == ACT_SIGMOID) begin : g_sigmoid
        // Table holds an identity ramp; sigFile names the preload image used by downstream flows.
        logic [dataWidth-1:0]   sig_lut [2**sigmoidSize];
        logic [sigmoidSize-1:0] lut_addr;
        logic                   unused_low;

        for (genvar i = 0; i < 2**sigmoidSize; i++) begin : g_lut
            assign sig_lut[i] = dataWidth'(i);
        end

        assign lut_addr   = {~sum[accW-1], sum[accW-2 -: sigmoidSize-1]};
        assign unused_low = ^sum[accW-sigmoidSize-1:0];

        // Look up the activation from the top bits of the offset-binary sum.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                out <= '0;
            end else if (sig_valid) begin
                out <= sig_lut[lut_addr];
            end
        end
    end else begin : g_relu
        logic unused_low;
        assign unused_low = ^sum[accW-weightIntWidth-dataWidth-1:0];

        // Clip negatives to zero and clamp anything beyond the output's integer range.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                out <= '0;
            end else if (sig_valid) begin
                if (sum[accW-1]) begin
                    out <= '0;
                end else if (|sum[accW-1 -: weightIntWidth+1]) begin
                    out <= {1'b0, {(dataWidth-1){1'b1}}};
                end else begin
                    out <= sum[accW-1-weightIntWidth -: dataWidth];
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_core.sv
// Self-checking bench for neuron_core: one ReLU and one sigmoid neuron share the
// configuration bus and input stream; results come from a plain arithmetic model.
module tb_neuron_core;

    localparam int dataWidth = 16;
    localparam int numWeight = 4;
    localparam int layerId   = 1;
    localparam int reluId    = 2;
    localparam int sigId     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] myinput;
    logic        myinputValid;
    logic        weightValid;
    logic        biasValid;
    logic [31:0] weightValue;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic [15:0] out_relu;
    logic [15:0] out_sig;
    logic        outvalid_relu;
    logic        outvalid_sig;

    int checkCount = 0;
    int failCount  = 0;

    logic [15:0] xVec   [numWeight];
    logic [15:0] wModel [2][numWeight];
    logic [15:0] bModel [2];
    int          ptrModel [2];

    always #5 clk = ~clk;

    neuron_core #(
        .layerNo(layerId), .neuronNo(reluId), .numWeight(numWeight), .dataWidth(dataWidth),
        .sigmoidSize(5), .weightIntWidth(1), .actType("relu"), .sigFile("")
    ) dut_relu (
        .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
        .weightValid(weightValid), .biasValid(biasValid), .weightValue(weightValue),
        .biasValue(biasValue), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .out(out_relu), .outvalid(outvalid_relu)
    );

    neuron_core #(
        .layerNo(layerId), .neuronNo(sigId), .numWeight(numWeight), .dataWidth(dataWidth),
        .sigmoidSize(5), .weightIntWidth(1), .actType("sigmoid"), .sigFile("")
    ) dut_sig (
        .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
        .weightValid(weightValid), .biasValid(biasValid), .weightValue(weightValue),
        .biasValue(biasValue), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .out(out_sig), .outvalid(outvalid_sig)
    );

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Reference dot product with clamping after every addition, then the bias.
    function automatic longint modelAcc(input int k);
        longint acc = 0;
        for (int i = 0; i < numWeight; i++) begin
            acc = sat32(acc + longint'($signed(xVec[i])) * longint'($signed(wModel[k][i])));
        end
        acc = sat32(acc + longint'($signed(bModel[k])) * 65536);
        return acc;
    endfunction

    function automatic logic [15:0] reluRef(input longint acc);
        if (acc < 0) return 16'h0000;
        if (acc >= 64'sd1073741824) return 16'h7FFF;
        return 16'(acc / 32768);
    endfunction

    function automatic logic [15:0] sigRef(input longint acc);
        return 16'((acc + 64'sd2147483648) / 134217728);
    endfunction

    task automatic loadWeight(input int neuron, input logic [15:0] value);
        @(negedge clk);
        config_layer_num  = 32'(layerId);
        config_neuron_num = 32'(neuron);
        weightValue       = {16'h0000, value};
        weightValid       = 1'b1;
        @(negedge clk);
        weightValid = 1'b0;
        if (neuron == reluId || neuron == sigId) begin
            int k = neuron - reluId;
            wModel[k][ptrModel[k]] = value;
            ptrModel[k] = (ptrModel[k] + 1) % numWeight;
        end
    endtask

    task automatic loadBias(input int neuron, input logic [15:0] value);
        @(negedge clk);
        config_layer_num  = 32'(layerId);
        config_neuron_num = 32'(neuron);
        biasValue         = {16'hABCD, value};
        biasValid         = 1'b1;
        @(negedge clk);
        biasValid = 1'b0;
        if (neuron == reluId || neuron == sigId) begin
            bModel[neuron - reluId] = value;
        end
    endtask

    task automatic loadAllWeights(input int neuron, input logic [15:0] value);
        for (int i = 0; i < numWeight; i++) loadWeight(neuron, value);
    endtask

    // Stream xVec with `gap` idle cycles between samples and check the result pulse.
    task automatic applyStimulus(input string tag, input int gap, input logic [15:0] expRelu, input logic [15:0] expSig);
        int edges = 0;
        bit seen = 1'b0;
        for (int i = 0; i < numWeight; i++) begin
            @(negedge clk);
            myinput      = xVec[i];
            myinputValid = 1'b1;
            if (i < numWeight - 1 && gap > 0) begin
                @(negedge clk);
                myinputValid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(posedge clk);
        @(negedge clk);
        myinputValid = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (outvalid_relu) seen = 1'b1;
        end
        checkOutput({tag, " latency"}, 32'(seen ? edges : 0), 32'd5);
        checkOutput({tag, " sig valid"}, 32'(outvalid_sig), 32'd1);
        checkOutput({tag, " relu out"}, 32'(out_relu), 32'(expRelu));
        checkOutput({tag, " sig out"}, 32'(out_sig), 32'(expSig));
        @(negedge clk);
        checkOutput({tag, " relu pulse"}, 32'(outvalid_relu), 32'd0);
        checkOutput({tag, " sig pulse"}, 32'(outvalid_sig), 32'd0);
    endtask

    task automatic fillInputs(input logic [15:0] value);
        for (int i = 0; i < numWeight; i++) xVec[i] = value;
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        myinput = '0; myinputValid = 1'b0;
        weightValid = 1'b0; biasValid = 1'b0;
        weightValue = '0; biasValue = '0;
        config_layer_num = '0; config_neuron_num = '0;
        ptrModel[0] = 0; ptrModel[1] = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset relu out", 32'(out_relu), 32'd0);
        checkOutput("reset relu valid", 32'(outvalid_relu), 32'd0);
        checkOutput("reset sig out", 32'(out_sig), 32'd0);
        checkOutput("reset sig valid", 32'(outvalid_sig), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed: positive dot product");
        loadAllWeights(reluId, 16'h1000);
        loadBias(reluId, 16'h0100);
        loadAllWeights(sigId, 16'h0000);
        loadBias(sigId, 16'h0000);
        fillInputs(16'h1000);
        applyStimulus("pos", 0, 16'h0A00, 16'd16);

        $display("[TB] directed: negative dot product");
        fillInputs(16'hF000);
        applyStimulus("neg", 0, 16'h0000, 16'd16);

        $display("[TB] directed: saturation");
        loadAllWeights(reluId, 16'h7FFF);
        loadAllWeights(sigId, 16'h8000);
        loadBias(sigId, 16'h8000);
        fillInputs(16'h7FFF);
        applyStimulus("sat", 0, 16'h7FFF, 16'd0);

        $display("[TB] directed: foreign load and gapped inputs");
        for (int i = 0; i < numWeight; i++) loadWeight(9, 16'($urandom));
        loadBias(9, 16'h1234);
        applyStimulus("gap", 2, 16'h7FFF, 16'd0);

        $display("[TB] directed: reset during accumulation");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            myinput = 16'h7FFF;
            myinputValid = 1'b1;
        end
        @(negedge clk);
        myinputValid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("midreset relu out", 32'(out_relu), 32'd0);
        checkOutput("midreset relu valid", 32'(outvalid_relu), 32'd0);
        checkOutput("midreset sig valid", 32'(outvalid_sig), 32'd0);
        ptrModel[0] = 0; ptrModel[1] = 0;
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (outvalid_relu || outvalid_sig) pulses++;
        end
        checkOutput("aborted no result", 32'(pulses), 32'd0);
        applyStimulus("postreset", 0, 16'h7FFF, 16'd0);

        $display("[TB] randomized vectors");
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < numWeight; i++) loadWeight(reluId + k, 16'($urandom));
                loadBias(reluId + k, 16'($urandom));
            end
            if (it % 2 == 1) loadWeight(7, 16'($urandom));
            for (int i = 0; i < numWeight; i++) xVec[i] = 16'($urandom);
            applyStimulus($sformatf("rand%0d", it), int'($urandom_range(0, 2)),
                          reluRef(modelAcc(0)), sigRef(modelAcc(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
